// File: rtl/bomb_blast_if.sv
// bomb_blast_if: tick/grid bundle between the game controller and bomb_blast.
// Signals:
//   bomb_tick    - one-cycle bomb time-step pulse (controller -> blast engine)
//   arena_in     - arena grid, 2 bits per cell, cell (i,j) at index i*10+j
//   bomb_in      - bomb fuse grid, same packing
//   arena_out    - post-blast arena grid
//   bomb_out     - post-tick bomb grid
//   flame_out    - one bit per burning cell
//   update_valid - one-cycle pulse: arena_out/bomb_out ready to load
//   busy         - tick in progress, up to and including the update_valid cycle
//   hit_a/hit_b  - sticky: player A/B stood in a flame
//   overrun      - sticky: a tick arrived while busy
interface bomb_blast_if;
    localparam int unsigned GRID_W  = 200;
    localparam int unsigned FLAME_W = 100;

    logic               bomb_tick;
    logic [GRID_W-1:0]  arena_in;
    logic [GRID_W-1:0]  bomb_in;
    logic [GRID_W-1:0]  arena_out;
    logic [GRID_W-1:0]  bomb_out;
    logic [FLAME_W-1:0] flame_out;
    logic               update_valid;
    logic               busy;
    logic               hit_a;
    logic               hit_b;
    logic               overrun;

    modport master (
        output bomb_tick, arena_in, bomb_in,
        input  arena_out, bomb_out, flame_out, update_valid, busy,
               hit_a, hit_b, overrun
    );

    modport slave (
        input  bomb_tick, arena_in, bomb_in,
        output arena_out, bomb_out, flame_out, update_valid, busy,
               hit_a, hit_b, overrun
    );
endinterface

// File: rtl/bomb_blast.sv
// bomb_blast: per-tick bomb engine for a 10x10 arena. On an accepted tick the
// arena and bomb grids are snapshotted, every cell is scanned in index order
// (decrementing fuses), each expiring bomb runs a fixed-length cross-shaped
// blast, and the updated grids are published with a one-cycle update_valid.
// Ports:
//   clk  - clock
//   rst  - synchronous active-high reset
//   bus  - bomb_blast_if.slave (tick, grids in/out, flame map, status flags)
// Parameter:
//   RADIUS - blast reach in cells along each direction (1..9)
module bomb_blast #(
    parameter int unsigned RADIUS = 2
) (
    input  logic        clk,
    input  logic        rst,
    bomb_blast_if.slave bus
);
    localparam int unsigned CELLS    = 100;
    localparam int unsigned IDX_W    = 7;
    localparam int unsigned RC_W     = 4;
    localparam int unsigned LAST_IDX = CELLS - 1;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_SCAN  = 2'd1;
    localparam logic [1:0] S_BLAST = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    localparam logic [1:0] C_WALL  = 2'd1;
    localparam logic [1:0] C_PL_A  = 2'd2;
    localparam logic [1:0] C_PL_B  = 2'd3;

    logic [1:0]             state_q,      state_d;
    logic [IDX_W-1:0]       idx_q,        idx_d;
    logic [RC_W-1:0]        cen_row_q,    cen_row_d;
    logic [RC_W-1:0]        cen_col_q,    cen_col_d;
    logic [1:0]             dir_q,        dir_d;
    logic [RC_W-1:0]        dist_q,       dist_d;
    logic                   stop_q,       stop_d;
    logic [CELLS-1:0][1:0]  arena_q,      arena_d;
    logic [CELLS-1:0][1:0]  bomb_q,       bomb_d;
    logic [CELLS-1:0]       flame_q,      flame_d;
    logic [CELLS-1:0][1:0]  arena_out_q,  arena_out_d;
    logic [CELLS-1:0][1:0]  bomb_out_q,   bomb_out_d;
    logic                   update_valid_q, update_valid_d;
    logic                   busy_q,       busy_d;
    logic                   hit_a_q,      hit_a_d;
    logic                   hit_b_q,      hit_b_d;
    logic                   overrun_q,    overrun_d;

    logic [1:0]             scan_fuse;
    logic [RC_W-1:0]        scan_row;
    logic [RC_W-1:0]        scan_col;
    logic signed [4:0]      base_row_s;
    logic signed [4:0]      base_col_s;
    logic signed [4:0]      dist_s;
    logic signed [4:0]      tgt_row_s;
    logic signed [4:0]      tgt_col_s;
    logic                   tgt_in_grid;
    logic [IDX_W-1:0]       tgt_idx;

    assign bus.arena_out    = arena_out_q;
    assign bus.bomb_out     = bomb_out_q;
    assign bus.flame_out    = flame_q;
    assign bus.update_valid = update_valid_q;
    assign bus.busy         = busy_q;
    assign bus.hit_a        = hit_a_q;
    assign bus.hit_b        = hit_b_q;
    assign bus.overrun      = overrun_q;

    // Cell currently visited by the scan.
    assign scan_fuse = bomb_q[idx_q];
    assign scan_row  = RC_W'(idx_q / IDX_W'(10));
    assign scan_col  = RC_W'(idx_q % IDX_W'(10));

    // Blast target: centre offset by dist along dir (0 up, 1 down, 2 left, 3 right).
    // Signed 5-bit math; any result outside 0..9 (including wrap above +15) is off-grid.
    always_comb begin
        base_row_s = $signed({1'b0, cen_row_q});
        base_col_s = $signed({1'b0, cen_col_q});
        dist_s     = $signed({1'b0, dist_q});
        tgt_row_s  = base_row_s;
        tgt_col_s  = base_col_s;
        case (dir_q)
            2'd0:    tgt_row_s = base_row_s - dist_s;
            2'd1:    tgt_row_s = base_row_s + dist_s;
            2'd2:    tgt_col_s = base_col_s - dist_s;
            default: tgt_col_s = base_col_s + dist_s;
        endcase
        tgt_in_grid = (tgt_row_s >= 5'sd0) && (tgt_row_s <= 5'sd9) &&
                      (tgt_col_s >= 5'sd0) && (tgt_col_s <= 5'sd9);
        tgt_idx     = IDX_W'(tgt_row_s[3:0]) * IDX_W'(10) + IDX_W'(tgt_col_s[3:0]);
    end

    // Next-state and datapath.
    always_comb begin
        state_d        = state_q;
        idx_d          = idx_q;
        cen_row_d      = cen_row_q;
        cen_col_d      = cen_col_q;
        dir_d          = dir_q;
        dist_d         = dist_q;
        stop_d         = stop_q;
        arena_d        = arena_q;
        bomb_d         = bomb_q;
        flame_d        = flame_q;
        arena_out_d    = arena_out_q;
        bomb_out_d     = bomb_out_q;
        update_valid_d = 1'b0;
        busy_d         = busy_q;
        hit_a_d        = hit_a_q;
        hit_b_d        = hit_b_q;
        overrun_d      = overrun_q;

        if (bus.bomb_tick && busy_q) begin
            overrun_d = 1'b1;
        end
        if (update_valid_q) begin
            busy_d = 1'b0;
        end

        case (state_q)
            S_IDLE: begin
                if (bus.bomb_tick && !busy_q) begin
                    arena_d = bus.arena_in;
                    bomb_d  = bus.bomb_in;
                    flame_d = '0;
                    idx_d   = '0;
                    busy_d  = 1'b1;
                    state_d = S_SCAN;
                end
            end

            S_SCAN: begin
                if (scan_fuse == 2'd1) begin
                    bomb_d[idx_q] = 2'd0;
                    cen_row_d     = scan_row;
                    cen_col_d     = scan_col;
                    dir_d         = 2'd0;
                    dist_d        = '0;
                    stop_d        = 1'b0;
                    state_d       = S_BLAST;
                end else begin
                    if (scan_fuse >= 2'd2) begin
                        bomb_d[idx_q] = scan_fuse - 2'd1;
                    end
                    if (idx_q == IDX_W'(LAST_IDX)) begin
                        state_d = S_DONE;
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                    end
                end
            end

            S_BLAST: begin
                if (tgt_in_grid && !stop_q) begin
                    flame_d[tgt_idx] = 1'b1;
                    case (arena_q[tgt_idx])
                        C_WALL: begin
                            arena_d[tgt_idx] = 2'd0;
                            // A wall on the centre cell does not shield the up arm.
                            if (dist_q != '0) begin
                                stop_d = 1'b1;
                            end
                        end
                        C_PL_A:  hit_a_d = 1'b1;
                        C_PL_B:  hit_b_d = 1'b1;
                        default: ;
                    endcase
                    // Chained bombs must end this tick at fuse 1. A not-yet-scanned
                    // cell still gets decremented by the scan, so park it at 2.
                    if (bomb_q[tgt_idx] >= 2'd2) begin
                        bomb_d[tgt_idx] = (tgt_idx > idx_q) ? 2'd2 : 2'd1;
                    end
                end

                if (dist_q == RC_W'(RADIUS)) begin
                    if (dir_q == 2'd3) begin
                        if (idx_q == IDX_W'(LAST_IDX)) begin
                            state_d = S_DONE;
                        end else begin
                            idx_d   = idx_q + IDX_W'(1);
                            state_d = S_SCAN;
                        end
                    end else begin
                        dir_d  = dir_q + 2'd1;
                        dist_d = RC_W'(1);
                        stop_d = 1'b0;
                    end
                end else begin
                    dist_d = dist_q + RC_W'(1);
                end
            end

            default: begin
                arena_out_d    = arena_q;
                bomb_out_d     = bomb_q;
                update_valid_d = 1'b1;
                state_d        = S_IDLE;
            end
        endcase
    end

    // State registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= S_IDLE;
            idx_q          <= '0;
            cen_row_q      <= '0;
            cen_col_q      <= '0;
            dir_q          <= '0;
            dist_q         <= '0;
            stop_q         <= 1'b0;
            arena_q        <= '0;
            bomb_q         <= '0;
            flame_q        <= '0;
            arena_out_q    <= '0;
            bomb_out_q     <= '0;
            update_valid_q <= 1'b0;
            busy_q         <= 1'b0;
            hit_a_q        <= 1'b0;
            hit_b_q        <= 1'b0;
            overrun_q      <= 1'b0;
        end else begin
            state_q        <= state_d;
            idx_q          <= idx_d;
            cen_row_q      <= cen_row_d;
            cen_col_q      <= cen_col_d;
            dir_q          <= dir_d;
            dist_q         <= dist_d;
            stop_q         <= stop_d;
            arena_q        <= arena_d;
            bomb_q         <= bomb_d;
            flame_q        <= flame_d;
            arena_out_q    <= arena_out_d;
            bomb_out_q     <= bomb_out_d;
            update_valid_q <= update_valid_d;
            busy_q         <= busy_d;
            hit_a_q        <= hit_a_d;
            hit_b_q        <= hit_b_d;
            overrun_q      <= overrun_d;
        end
    end
endmodule
